// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller and the datapath muxes it steers.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXE    = 4'd2,
        S_ALUWB  = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
    } instr_e;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [1:0] WR_RT = 2'b00;
    localparam logic [1:0] WR_RD = 2'b01;
    localparam logic [1:0] WR_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle; MC_CTRL_MEM_WAIT_EN adds the mem_rdy handshake.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic       mem_rdy;
`endif
    logic       PCWrite;
    logic       IRWrite;
    logic       RFWr;
    logic       DMWr;
    logic [1:0] NPCOp;
    logic [2:0] ALUOp;
    logic       ALUSrc;
    logic       EXTOp;
    logic [1:0] WRSel;
    logic [1:0] WDSel;
    logic       ill_instr;

`ifdef MC_CTRL_MEM_WAIT_EN
    modport master (
        input  op, funct, zero, mem_rdy,
        output PCWrite, IRWrite, RFWr, DMWr, NPCOp, ALUOp, ALUSrc, EXTOp, WRSel, WDSel,
               ill_instr
    );
    modport slave (
        output op, funct, zero, mem_rdy,
        input  PCWrite, IRWrite, RFWr, DMWr, NPCOp, ALUOp, ALUSrc, EXTOp, WRSel, WDSel,
               ill_instr
    );
`else
    modport master (
        input  op, funct, zero,
        output PCWrite, IRWrite, RFWr, DMWr, NPCOp, ALUOp, ALUSrc, EXTOp, WRSel, WDSel,
               ill_instr
    );
    modport slave (
        output op, funct, zero,
        input  PCWrite, IRWrite, RFWr, DMWr, NPCOp, ALUOp, ALUSrc, EXTOp, WRSel, WDSel,
               ill_instr
    );
`endif
endinterface

// File: rtl/mc_decode.sv
// Combinational op/funct decoder producing the instruction class.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output instr_e     o_instr
);

    always_comb begin
        o_instr = I_ILL;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADDU: o_instr = I_ADDU;
                    FUNCT_SUBU: o_instr = I_SUBU;
                    FUNCT_JR:   o_instr = I_JR;
                    default:    o_instr = I_ILL;
                endcase
            end
            OP_ORI:  o_instr = I_ORI;
            OP_LUI:  o_instr = I_LUI;
            OP_LW:   o_instr = I_LW;
            OP_SW:   o_instr = I_SW;
            OP_BEQ:  o_instr = I_BEQ;
            OP_J:    o_instr = I_J;
            OP_JAL:  o_instr = I_JAL;
            default: o_instr = I_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional MC_CTRL_MEM_WAIT_EN stalls fetch and memory states on mem_rdy.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [3:0] RST_STATE = 4'd0
) (
    input logic       clk,
    input logic       rst,
    mc_ctrl_if.master bus
);

    state_e     r_state;
    state_e     w_state;
    instr_e     w_instr;
    logic       w_rdy;
    logic       w_pcwrite, w_irwrite, w_rfwr, w_dmwr, w_alusrc, w_extop, w_ill;
    logic [1:0] w_npcop, w_wrsel, w_wdsel;
    logic [2:0] w_aluop;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign w_rdy = bus.mem_rdy;
`else
    assign w_rdy = 1'b1;
`endif

    mc_decode u_decode (
        .i_op    (bus.op),
        .i_funct (bus.funct),
        .o_instr (w_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= state_e'(RST_STATE);
        end else begin
            case (r_state)
                S_FETCH:  if (w_rdy) r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_instr)
                        I_LW, I_SW:                    r_state <= S_MEMADR;
                        I_ADDU, I_SUBU, I_ORI, I_LUI:  r_state <= S_EXE;
                        I_BEQ:                         r_state <= S_BRANCH;
                        I_J, I_JAL, I_JR:              r_state <= S_JUMP;
                        default:                       r_state <= S_FETCH;
                    endcase
                end
                S_EXE:    r_state <= S_ALUWB;
                S_MEMADR: r_state <= (w_instr == I_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (w_rdy) r_state <= S_MEMWB;
                S_MEMWR:  if (w_rdy) r_state <= S_FETCH;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // A reset in progress presents fetch outputs so an abandoned write never fires.
    assign w_state = rst ? S_FETCH : r_state;

    always_comb begin
        w_pcwrite = 1'b0;
        w_irwrite = 1'b0;
        w_rfwr    = 1'b0;
        w_dmwr    = 1'b0;
        w_npcop   = NPC_PC4;
        w_aluop   = ALU_ADD;
        w_alusrc  = 1'b0;
        w_extop   = 1'b0;
        w_wrsel   = WR_RT;
        w_wdsel   = WD_ALU;
        w_ill     = 1'b0;
        case (w_state)
            S_FETCH: begin
                w_pcwrite = w_rdy;
                w_irwrite = w_rdy;
            end
            S_DECODE: w_ill = (w_instr == I_ILL);
            S_EXE: begin
                case (w_instr)
                    I_SUBU: w_aluop = ALU_SUB;
                    I_ORI: begin
                        w_aluop  = ALU_OR;
                        w_alusrc = 1'b1;
                    end
                    I_LUI: begin
                        w_aluop  = ALU_LUI;
                        w_alusrc = 1'b1;
                    end
                    default: w_aluop = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                w_rfwr  = 1'b1;
                w_wrsel = (w_instr == I_ADDU || w_instr == I_SUBU) ? WR_RD : WR_RT;
            end
            S_MEMADR: begin
                w_alusrc = 1'b1;
                w_extop  = 1'b1;
            end
            S_MEMWB: begin
                w_rfwr  = 1'b1;
                w_wdsel = WD_MEM;
            end
            S_MEMWR: w_dmwr = w_rdy;
            S_BRANCH: begin
                w_aluop   = ALU_SUB;
                w_npcop   = NPC_BRANCH;
                w_pcwrite = bus.zero;
            end
            S_JUMP: begin
                w_pcwrite = 1'b1;
                w_npcop   = (w_instr == I_JR) ? NPC_JR : NPC_JUMP;
                if (w_instr == I_JAL) begin
                    w_rfwr  = 1'b1;
                    w_wrsel = WR_RA;
                    w_wdsel = WD_PC;
                end
            end
            default: ;
        endcase
    end

    assign bus.PCWrite   = w_pcwrite;
    assign bus.IRWrite   = w_irwrite;
    assign bus.RFWr      = w_rfwr;
    assign bus.DMWr      = w_dmwr;
    assign bus.NPCOp     = w_npcop;
    assign bus.ALUOp     = w_aluop;
    assign bus.ALUSrc    = w_alusrc;
    assign bus.EXTOp     = w_extop;
    assign bus.WRSel     = w_wrsel;
    assign bus.WDSel     = w_wdsel;
    assign bus.ill_instr = w_ill;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed literal checks plus randomized run against an
// instruction/step table model.
module tb_mc_ctrl;

    localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
    localparam int K_SW = 6, K_BEQ = 7, K_J = 8, K_JAL = 9, K_ILL = 10, K_ILLR = 11;
`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WaitEn = 1'b1;
`else
    localparam bit WaitEn = 1'b0;
`endif

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rfwr;
        logic       dmwr;
        logic [1:0] npc;
        logic [2:0] alu;
        logic       alusrc;
        logic       ext;
        logic [1:0] wrsel;
        logic [1:0] wdsel;
        logic       ill;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rdy_v = 1'b1;
    int   m_inst = K_ADDU;
    int   m_step = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_cyc = 0;

    mc_ctrl_if u_if ();

    mc_ctrl #(.RST_STATE(4'd0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    function automatic int last_step(input int k);
        case (k)
            K_ILL, K_ILLR:               return 1;
            K_BEQ, K_J, K_JAL, K_JR:     return 2;
            K_LW:                        return 4;
            default:                     return 3;
        endcase
    endfunction

    function automatic bit stall_step(input int k, input int s);
        return (s == 0) || (s == 3 && (k == K_LW || k == K_SW));
    endfunction

    // Expected outputs by instruction and cycle within it.
    function automatic out_t exp_out(input int k, input int s, input bit z, input bit r);
        out_t e;
        e = '0;
        if (s == 0) begin
            e.pcw = r;
            e.irw = r;
        end else if (s == 1) begin
            e.ill = (k >= K_ILL);
        end else begin
            case (k)
                K_ADDU: if (s == 3) begin e.rfwr = 1; e.wrsel = 2'b01; end
                K_SUBU: begin
                    if (s == 2) e.alu = 3'b001;
                    if (s == 3) begin e.rfwr = 1; e.wrsel = 2'b01; end
                end
                K_ORI: begin
                    if (s == 2) begin e.alu = 3'b010; e.alusrc = 1; end
                    if (s == 3) e.rfwr = 1;
                end
                K_LUI: begin
                    if (s == 2) begin e.alu = 3'b011; e.alusrc = 1; end
                    if (s == 3) e.rfwr = 1;
                end
                K_LW: begin
                    if (s == 2) begin e.alusrc = 1; e.ext = 1; end
                    if (s == 4) begin e.rfwr = 1; e.wdsel = 2'b01; end
                end
                K_SW: begin
                    if (s == 2) begin e.alusrc = 1; e.ext = 1; end
                    if (s == 3) e.dmwr = r;
                end
                K_BEQ: begin e.alu = 3'b001; e.npc = 2'b01; e.pcw = z; end
                K_J:   begin e.pcw = 1; e.npc = 2'b10; end
                K_JAL: begin
                    e.pcw = 1; e.npc = 2'b10; e.rfwr = 1; e.wrsel = 2'b10; e.wdsel = 2'b10;
                end
                K_JR:  begin e.pcw = 1; e.npc = 2'b11; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic drive_op(input int k);
        logic [5:0] f;
        f = 6'($urandom_range(0, 63));
        u_if.funct = f;
        case (k)
            K_ADDU: begin u_if.op = 6'h00; u_if.funct = 6'h21; end
            K_SUBU: begin u_if.op = 6'h00; u_if.funct = 6'h23; end
            K_JR:   begin u_if.op = 6'h00; u_if.funct = 6'h08; end
            K_ORI:  u_if.op = 6'h0D;
            K_LUI:  u_if.op = 6'h0F;
            K_LW:   u_if.op = 6'h23;
            K_SW:   u_if.op = 6'h2B;
            K_BEQ:  u_if.op = 6'h04;
            K_J:    u_if.op = 6'h02;
            K_JAL:  u_if.op = 6'h03;
            K_ILL:  u_if.op = 6'h3F;
            default: begin u_if.op = 6'h00; u_if.funct = 6'h20; end
        endcase
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: advance the model on the edge, drive new inputs, compare at negedge.
    task automatic do_cycle(input bit rst_v, input bit zero_v, input bit rdy_in, input int want);
        bit   rdy_eff;
        out_t act;
        out_t exp;
        @(posedge clk);
        rdy_eff = WaitEn ? rdy_v : 1'b1;
        if (rst) m_step = 0;
        else if (!(stall_step(m_inst, m_step) && !rdy_eff))
            m_step = (m_step == last_step(m_inst)) ? 0 : m_step + 1;
        #1;
        rst = rst_v;
        u_if.zero = zero_v;
        rdy_v = rdy_in;
`ifdef MC_CTRL_MEM_WAIT_EN
        u_if.mem_rdy = rdy_in;
`endif
        if (m_step == 0) begin
            m_inst = (want >= 0) ? want : int'($urandom_range(0, 11));
            drive_op(m_inst);
        end
        @(negedge clk);
        n_cyc++;
        act = {u_if.PCWrite, u_if.IRWrite, u_if.RFWr, u_if.DMWr, u_if.NPCOp, u_if.ALUOp,
               u_if.ALUSrc, u_if.EXTOp, u_if.WRSel, u_if.WDSel, u_if.ill_instr};
        n_checks++;
        if (rst) begin
            if (act.rfwr !== 1'b0 || act.dmwr !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_wr_en cyc %0d: got RFWr=%b DMWr=%b required 0/0",
                         n_cyc, act.rfwr, act.dmwr);
            end
        end else begin
            exp = exp_out(m_inst, m_step, zero_v, WaitEn ? rdy_in : 1'b1);
            if (act !== exp) begin
                n_fail++;
                $display("FAIL outputs cyc %0d inst %0d step %0d: got %h required %h",
                         n_cyc, m_inst, m_step, act, exp);
            end
        end
    endtask

    initial begin
        u_if.op = 6'h00;
        u_if.funct = 6'h00;
        u_if.zero = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
        u_if.mem_rdy = 1'b1;
`endif
        do_cycle(1, 0, 1, K_ADDU);
        do_cycle(1, 0, 1, K_ADDU);
        // addu
        do_cycle(0, 0, 1, K_ADDU);
        chk("reset_pcwrite", 8'(u_if.PCWrite), 8'd1);
        chk("reset_irwrite", 8'(u_if.IRWrite), 8'd1);
        do_cycle(0, 0, 1, K_ADDU);
        do_cycle(0, 0, 1, K_ADDU);
        chk("addu_c3_rfwr", 8'(u_if.RFWr), 8'd0);
        do_cycle(0, 0, 1, K_ADDU);
        chk("addu_c4_rfwr", 8'(u_if.RFWr), 8'd1);
        chk("addu_c4_wrsel", 8'(u_if.WRSel), 8'd1);
        chk("addu_c4_wdsel", 8'(u_if.WDSel), 8'd0);
        chk("addu_c4_aluop", 8'(u_if.ALUOp), 8'd0);
        // lw
        repeat (4) do_cycle(0, 0, 1, K_LW);
        chk("lw_c4_rfwr", 8'(u_if.RFWr), 8'd0);
        do_cycle(0, 0, 1, K_LW);
        chk("lw_c5_rfwr", 8'(u_if.RFWr), 8'd1);
        chk("lw_c5_wdsel", 8'(u_if.WDSel), 8'd1);
        // sw
        repeat (3) do_cycle(0, 0, 1, K_SW);
        do_cycle(0, 0, 1, K_SW);
        chk("sw_c4_dmwr", 8'(u_if.DMWr), 8'd1);
        chk("sw_c4_rfwr", 8'(u_if.RFWr), 8'd0);
        // beq taken, then not taken
        repeat (2) do_cycle(0, 1, 1, K_BEQ);
        do_cycle(0, 1, 1, K_BEQ);
        chk("beq_t_pcwrite", 8'(u_if.PCWrite), 8'd1);
        chk("beq_t_npcop", 8'(u_if.NPCOp), 8'd1);
        repeat (2) do_cycle(0, 0, 1, K_BEQ);
        do_cycle(0, 0, 1, K_BEQ);
        chk("beq_nt_pcwrite", 8'(u_if.PCWrite), 8'd0);
        // jal, jr
        repeat (2) do_cycle(0, 0, 1, K_JAL);
        do_cycle(0, 0, 1, K_JAL);
        chk("jal_pcwrite", 8'(u_if.PCWrite), 8'd1);
        chk("jal_npcop", 8'(u_if.NPCOp), 8'd2);
        chk("jal_rfwr", 8'(u_if.RFWr), 8'd1);
        chk("jal_wrsel", 8'(u_if.WRSel), 8'd2);
        chk("jal_wdsel", 8'(u_if.WDSel), 8'd2);
        repeat (2) do_cycle(0, 0, 1, K_JR);
        do_cycle(0, 0, 1, K_JR);
        chk("jr_npcop", 8'(u_if.NPCOp), 8'd3);
        chk("jr_rfwr", 8'(u_if.RFWr), 8'd0);
        // illegal op 0x3F
        do_cycle(0, 0, 1, K_ILL);
        do_cycle(0, 0, 1, K_ILL);
        chk("ill_pulse", 8'(u_if.ill_instr), 8'd1);
        chk("ill_wr_en", 8'({u_if.RFWr, u_if.DMWr, u_if.PCWrite}), 8'd0);
        do_cycle(0, 0, 1, K_SW);
        chk("ill_cleared", 8'(u_if.ill_instr), 8'd0);
        chk("ill_next_fetch", 8'(u_if.IRWrite), 8'd1);
        // reset held for two edges while sw sits in its write state
        repeat (2) do_cycle(0, 0, 1, K_SW);
        do_cycle(1, 0, 1, K_SW);
        chk("rst_memwr_dmwr", 8'(u_if.DMWr), 8'd0);
        do_cycle(1, 0, 1, K_J);
        do_cycle(0, 0, 1, K_J);
        chk("rst_post_pcwrite", 8'(u_if.PCWrite), 8'd1);
        chk("rst_post_irwrite", 8'(u_if.IRWrite), 8'd1);
        chk("rst_post_dmwr", 8'(u_if.DMWr), 8'd0);
        repeat (2) do_cycle(0, 0, 1, K_J);
`ifdef MC_CTRL_MEM_WAIT_EN
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 0, 0, K_J);
            chk("stall_pcwrite", 8'(u_if.PCWrite), 8'd0);
            chk("stall_irwrite", 8'(u_if.IRWrite), 8'd0);
        end
        do_cycle(0, 0, 1, K_J);
        chk("unstall_pcwrite", 8'(u_if.PCWrite), 8'd1);
        chk("unstall_irwrite", 8'(u_if.IRWrite), 8'd1);
        repeat (2) do_cycle(0, 0, 1, K_J);
`endif
        for (int i = 0; i < 3000; i++) begin
            do_cycle($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) != 0, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
